// File: rtl/bp_fe_pkg.sv
// Shared front-end types: PC sequencer FSM states and the fetch-pipeline stage record.
`define BP_FE_DECLARE_PC_SEQ_STAGE_S(vaddr_width) \
    typedef struct packed { \
        logic                   v; \
        logic [vaddr_width-1:0] pc; \
    } bp_fe_pc_seq_stage_s;

package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_wait  = 2'd0,
        e_stall = 2'd1,
        e_run   = 2'd2
    } bp_fe_pc_seq_state_e;

endpackage

// File: rtl/bp_fe_pc_seq_pipe.sv
// In-flight fetch tracker: depth_p-stage shift register of {valid, pc}; kill clears
// the valid of every entry moving into stages 1..depth_p-1.
module bp_fe_pc_seq_pipe
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int depth_p       = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               in_v_i,
    input  logic [vaddr_width_p-1:0]           in_pc_i,
    input  logic                               kill_i,
    output logic [depth_p-1:0]                 v_o,
    output logic [depth_p*vaddr_width_p-1:0]   pc_o
);

    `BP_FE_DECLARE_PC_SEQ_STAGE_S(vaddr_width_p)

    bp_fe_pc_seq_stage_s [depth_p-1:0] stage_q;
    bp_fe_pc_seq_stage_s [depth_p-1:0] stage_d;

    always_comb begin
        stage_d[0].v  = in_v_i;
        stage_d[0].pc = in_pc_i;
        for (int i = 1; i < depth_p; i++) begin
            stage_d[i].v  = stage_q[i-1].v & ~kill_i;
            stage_d[i].pc = stage_q[i-1].pc;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    for (genvar g = 0; g < depth_p; g++) begin : g_out
        assign v_o[g]                                  = stage_q[g].v;
        assign pc_o[g*vaddr_width_p +: vaddr_width_p] = stage_q[g].pc;
    end

endmodule

// File: rtl/bp_fe_pc_seq.sv
// Front-end PC sequencer: picks the next fetch PC (redirect, restart, override, BTB,
// sequential), replays unaccepted requests and tracks fetches through depth_p stages.
module bp_fe_pc_seq
    import bp_fe_pkg::*;
#(
    parameter int          vaddr_width_p = 39,
    parameter int          depth_p       = 2,
    parameter int          fetch_bytes_p = 4,
    parameter int          instr_align_p = 4,
    parameter logic [63:0] boot_pc_p     = 64'h0080000000
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             redirect_v_i,
    input  logic [vaddr_width_p-1:0]         redirect_pc_i,
    input  logic                             ovr_v_i,
    input  logic [vaddr_width_p-1:0]         ovr_pc_i,
    input  logic                             pred_v_i,
    input  logic [vaddr_width_p-1:0]         pred_pc_i,
    input  logic                             fail_i,
    input  logic                             exception_i,
    input  logic                             hold_i,
    output logic                             fetch_v_o,
    output logic [vaddr_width_p-1:0]         fetch_pc_o,
    input  logic                             fetch_yumi_i,
    output logic [depth_p-1:0]               stage_v_o,
    output logic [depth_p*vaddr_width_p-1:0] stage_pc_o,
    output logic [depth_p-2:0]               poison_o,
    output logic                             misalign_o
);

    localparam int                       last_lp       = depth_p - 1;
    localparam logic [vaddr_width_p-1:0] align_mask_lp = vaddr_width_p'(instr_align_p - 1);
    localparam logic [vaddr_width_p-1:0] fetch_mask_lp = vaddr_width_p'(fetch_bytes_p - 1);
    localparam logic [vaddr_width_p-1:0] fetch_inc_lp  = vaddr_width_p'(fetch_bytes_p);
    localparam logic [vaddr_width_p-1:0] boot_pc_lp    = vaddr_width_p'(boot_pc_p);

    // Next fetch block start; the add wraps at 2^vaddr_width_p.
    function automatic logic [vaddr_width_p-1:0] seq_pc(input logic [vaddr_width_p-1:0] pc);
        return (pc & ~fetch_mask_lp) + fetch_inc_lp;
    endfunction

    bp_fe_pc_seq_state_e state_q, state_d;
    logic [vaddr_width_p-1:0] resume_q, resume_d;
    logic [vaddr_width_p-1:0] held_q, held_d;

    logic [depth_p-1:0]               stage_v;
    logic [depth_p*vaddr_width_p-1:0] stage_pc;
    logic [vaddr_width_p-1:0]         stage0_pc;
    logic [vaddr_width_p-1:0]         resolve_pc;

    logic                     resolve_v;
    logic                     exc_v;
    logic                     fail_v;
    logic                     ovr_v;
    logic                     mis;
    logic                     kill;
    logic                     fetch_v;
    logic                     accept;
    logic [vaddr_width_p-1:0] fetch_pc;

    assign stage0_pc  = stage_pc[0 +: vaddr_width_p];
    assign resolve_pc = stage_pc[last_lp*vaddr_width_p +: vaddr_width_p];

    // Resolve-stage events only count when the resolve stage holds a live fetch.
    assign resolve_v = stage_v[last_lp];
    assign exc_v     = exception_i & resolve_v;
    assign fail_v    = fail_i & resolve_v;
    assign ovr_v     = ovr_v_i & resolve_v;
    assign mis       = redirect_v_i & ((redirect_pc_i & align_mask_lp) != '0);
    assign kill      = redirect_v_i | fail_v | exc_v | ovr_v;
    assign accept    = fetch_v & fetch_yumi_i;

    bp_fe_pc_seq_pipe #(
        .vaddr_width_p(vaddr_width_p),
        .depth_p      (depth_p)
    ) pipe (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .in_v_i (accept),
        .in_pc_i(fetch_pc),
        .kill_i (kill),
        .v_o    (stage_v),
        .pc_o   (stage_pc)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_wait;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall exit uses the accepted handshake, so a yumi during hold cannot skip the replay.
    always_comb begin
        state_d = state_q;
        if (mis) begin
            state_d = e_wait;
        end else if (redirect_v_i) begin
            state_d = accept ? e_run : e_stall;
        end else begin
            unique case (state_q)
                e_wait:  state_d = e_wait;
                e_stall: if (accept) state_d = e_run;
                e_run: begin
                    if (exc_v)       state_d = e_wait;
                    else if (fail_v) state_d = e_stall;
                end
                default: state_d = e_wait;
            endcase
        end
    end

    always_comb begin
        fetch_pc = held_q;
        if (redirect_v_i)               fetch_pc = redirect_pc_i;
        else if (state_q != e_run)      fetch_pc = resume_q;
        else if (exc_v | fail_v)        fetch_pc = resolve_pc;
        else if (ovr_v)                 fetch_pc = ovr_pc_i;
        else if (stage_v[0] & pred_v_i) fetch_pc = pred_pc_i;
        else if (stage_v[0])            fetch_pc = seq_pc(stage0_pc);

        fetch_v = ~mis & (redirect_v_i
                          | ((state_q != e_wait) & ~fail_v & ~exc_v & ~hold_i));
    end

    // Any request not accepted this cycle is remembered so the next cycle replays it.
    always_comb begin
        resume_d = resume_q;
        if (redirect_v_i)          resume_d = redirect_pc_i;
        else if (fail_v | exc_v)   resume_d = resolve_pc;

        held_d = held_q;
        if (!accept) held_d = fetch_pc;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resume_q <= boot_pc_lp;
            held_q   <= boot_pc_lp;
        end else begin
            resume_q <= resume_d;
            held_q   <= held_d;
        end
    end

    assign fetch_v_o  = fetch_v & ~reset_i;
    assign fetch_pc_o = fetch_pc;
    assign misalign_o = mis & ~reset_i;
    assign poison_o   = stage_v[depth_p-2:0] & {(depth_p-1){kill & ~reset_i}};
    assign stage_v_o  = stage_v;
    assign stage_pc_o = stage_pc;

endmodule

// File: tb/tb_bp_fe_pc_seq.sv
// Scoreboard bench: two sequencer configurations share randomized stimulus; a
// behavioural model queues expected outputs per cycle and a monitor compares them.
module tb_bp_fe_pc_seq;

    localparam int          W    = 39;
    localparam logic [63:0] BOOT = 64'h0080000000;
    localparam int          M_WAIT = 0, M_STALL = 1, M_RUN = 2;

    logic clk = 1'b0;
    logic rst;
    logic redir_v, ovr_v, pred_v, fail, exc, hold, yumi;
    logic [W-1:0] redir_pc, ovr_pc, pred_pc;

    logic           a_fv, a_mis;
    logic [W-1:0]   a_pc;
    logic [1:0]     a_sv;
    logic [2*W-1:0] a_spc;
    logic [0:0]     a_poison;
    logic           b_fv, b_mis;
    logic [W-1:0]   b_pc;
    logic [2:0]     b_sv;
    logic [3*W-1:0] b_spc;
    logic [1:0]     b_poison;

    always #5 clk = ~clk;

    bp_fe_pc_seq #(.vaddr_width_p(W), .depth_p(2), .fetch_bytes_p(4),
                   .instr_align_p(4), .boot_pc_p(BOOT)) dut_a (
        .clk_i(clk), .reset_i(rst),
        .redirect_v_i(redir_v), .redirect_pc_i(redir_pc),
        .ovr_v_i(ovr_v), .ovr_pc_i(ovr_pc), .pred_v_i(pred_v), .pred_pc_i(pred_pc),
        .fail_i(fail), .exception_i(exc), .hold_i(hold),
        .fetch_v_o(a_fv), .fetch_pc_o(a_pc), .fetch_yumi_i(yumi),
        .stage_v_o(a_sv), .stage_pc_o(a_spc), .poison_o(a_poison), .misalign_o(a_mis));

    bp_fe_pc_seq #(.vaddr_width_p(W), .depth_p(3), .fetch_bytes_p(8),
                   .instr_align_p(2), .boot_pc_p(BOOT)) dut_b (
        .clk_i(clk), .reset_i(rst),
        .redirect_v_i(redir_v), .redirect_pc_i(redir_pc),
        .ovr_v_i(ovr_v), .ovr_pc_i(ovr_pc), .pred_v_i(pred_v), .pred_pc_i(pred_pc),
        .fail_i(fail), .exception_i(exc), .hold_i(hold),
        .fetch_v_o(b_fv), .fetch_pc_o(b_pc), .fetch_yumi_i(yumi),
        .stage_v_o(b_sv), .stage_pc_o(b_spc), .poison_o(b_poison), .misalign_o(b_mis));

    typedef struct {
        bit           fv;
        logic [W-1:0] pc;
        bit [2:0]     sv;
        bit [1:0]     poison;
        bit           mis;
        logic [W-1:0] lastpc;
        bit           lastv;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Model configuration and state, indexed by DUT (0 = dut_a, 1 = dut_b).
    int unsigned     dep[2] = '{2, 3};
    longint unsigned fbw[2] = '{4, 8};
    longint unsigned alw[2] = '{4, 2};
    int              mode[2];
    bit              msv[2][3];
    logic [W-1:0]    mpc[2][3];
    logic [W-1:0]    resume[2];
    logic [W-1:0]    held[2];
    bit              c_fv[2], c_kill[2], c_mis[2], c_fl[2], c_ex[2];
    logic [W-1:0]    c_pc[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mode[k]   = M_WAIT;
            resume[k] = W'(BOOT);
            held[k]   = W'(BOOT);
            for (int i = 0; i < 3; i++) begin
                msv[k][i] = 1'b0;
                mpc[k][i] = '0;
            end
        end
    endtask

    task automatic model_comb(input int k, output exp_t e);
        int              last;
        bit              vl, ex, fl, ov, mis;
        longint unsigned nx, rp;
        logic [W-1:0]    pc;
        last = int'(dep[k]) - 1;
        vl   = msv[k][last];
        ex   = exc & vl;
        fl   = fail & vl;
        ov   = ovr_v & vl;
        rp   = 64'(redir_pc);
        mis  = redir_v && ((rp % alw[k]) != 0);
        if (redir_v)                   pc = redir_pc;
        else if (mode[k] != M_RUN)     pc = resume[k];
        else if (ex || fl)             pc = mpc[k][last];
        else if (ov)                   pc = ovr_pc;
        else if (msv[k][0] && pred_v)  pc = pred_pc;
        else if (msv[k][0]) begin
            nx = 64'(mpc[k][0]);
            nx = (nx / fbw[k]) * fbw[k] + fbw[k];
            nx = nx % (64'd1 << W);
            pc = nx[W-1:0];
        end else                       pc = held[k];
        e.fv     = !mis && (redir_v || (mode[k] != M_WAIT && !fl && !ex && !hold));
        e.pc     = pc;
        e.mis    = mis;
        e.sv     = '0;
        e.poison = '0;
        for (int i = 0; i <= last; i++) e.sv[i] = msv[k][i];
        for (int i = 0; i < last; i++)  e.poison[i] = msv[k][i] & (redir_v | fl | ex | ov);
        e.lastv  = vl;
        e.lastpc = mpc[k][last];
        c_fv[k] = e.fv; c_pc[k] = pc; c_mis[k] = mis; c_fl[k] = fl; c_ex[k] = ex;
        c_kill[k] = redir_v | fl | ex | ov;
    endtask

    task automatic model_step(input int k);
        int           last;
        bit           acc;
        logic [W-1:0] oldlast;
        last    = int'(dep[k]) - 1;
        acc     = c_fv[k] & yumi;
        oldlast = mpc[k][last];
        for (int i = last; i >= 1; i--) begin
            msv[k][i] = msv[k][i-1] & !c_kill[k];
            mpc[k][i] = mpc[k][i-1];
        end
        msv[k][0] = acc;
        mpc[k][0] = c_pc[k];
        if (redir_v)                 resume[k] = redir_pc;
        else if (c_fl[k] || c_ex[k]) resume[k] = oldlast;
        if (!acc) held[k] = c_pc[k];
        if (c_mis[k])                mode[k] = M_WAIT;
        else if (redir_v)            mode[k] = acc ? M_RUN : M_STALL;
        else if (mode[k] == M_STALL) mode[k] = acc ? M_RUN : M_STALL;
        else if (mode[k] == M_RUN)   mode[k] = c_ex[k] ? M_WAIT : (c_fl[k] ? M_STALL : M_RUN);
    endtask

    task automatic cycle();
        exp_t e;
        model_comb(0, e); qa.push_back(e);
        model_comb(1, e); qb.push_back(e);
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        #1;
    endtask

    task automatic drive(input bit rv, input logic [W-1:0] rpc, input bit ov, input logic [W-1:0] opc,
                         input bit pv, input logic [W-1:0] ppc, input bit fl, input bit ex,
                         input bit hd, input bit y);
        redir_v = rv; redir_pc = rpc; ovr_v = ov; ovr_pc = opc; pred_v = pv; pred_pc = ppc;
        fail = fl; exc = ex; hold = hd; yumi = y;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, '0, 0, '0, 0, '0, 0, 0, 0, 1);
            cycle();
        end
    endtask

    task automatic redirect(input logic [W-1:0] pc);
        drive(1, pc, 0, '0, 0, '0, 0, 0, 0, 1);
        cycle();
    endtask

    function automatic logic [W-1:0] rnd_pc();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if ($urandom_range(0, 3) == 0) r[W-1:4] = '1;
        if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
        return r[W-1:0];
    endfunction

    // Monitor: pops one expected record per DUT every cycle and compares the outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a.fetch_v", 64'(a_fv), 64'(e.fv));
                if (e.fv) chk("a.fetch_pc", 64'(a_pc), 64'(e.pc));
                chk("a.stage_v", 64'(a_sv), 64'(e.sv));
                chk("a.poison", 64'(a_poison), 64'(e.poison));
                chk("a.misalign", 64'(a_mis), 64'(e.mis));
                if (e.lastv) chk("a.resolve_pc", 64'(a_spc[W +: W]), 64'(e.lastpc));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b.fetch_v", 64'(b_fv), 64'(e.fv));
                if (e.fv) chk("b.fetch_pc", 64'(b_pc), 64'(e.pc));
                chk("b.stage_v", 64'(b_sv), 64'(e.sv));
                chk("b.poison", 64'(b_poison), 64'(e.poison));
                chk("b.misalign", 64'(b_mis), 64'(e.mis));
                if (e.lastv) chk("b.resolve_pc", 64'(b_spc[2*W +: W]), 64'(e.lastpc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, '0, 0, '0, 0, '0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.a_fetch_v", 64'(a_fv), 64'd0);
        chk("reset.a_stage_v", 64'(a_sv), 64'd0);
        chk("reset.a_stage_pc", 64'(a_spc[W-1:0]), 64'd0);
        chk("reset.b_stage_v", 64'(b_sv), 64'd0);
        chk("reset.b_poison", 64'(b_poison), 64'd0);
        chk("reset.b_misalign", 64'(b_mis), 64'd0);
        rst = 1'b0;

        // Directed scenarios.
        redirect(W'(64'h80000000));
        idle(3);
        redirect(W'(64'h1004));
        idle(3);
        drive(0, '0, 0, '0, 1, W'(64'h2000), 0, 0, 0, 1); cycle();
        drive(0, '0, 1, W'(64'h3000), 1, W'(64'h2000), 0, 0, 0, 1); cycle();
        idle(2);
        redirect(W'(64'h4000));
        idle(2);
        drive(0, '0, 1, W'(64'h5000), 0, '0, 1, 0, 0, 1); cycle();
        idle(3);
        drive(0, '0, 0, '0, 0, '0, 0, 1, 0, 1); cycle();
        idle(3);
        redirect(W'(64'h1002));
        idle(2);
        redirect(W'(64'h7FFFFFFFFC));
        idle(3);
        drive(0, '0, 0, '0, 0, '0, 0, 0, 1, 1); cycle(); cycle();
        drive(0, '0, 0, '0, 0, '0, 0, 0, 0, 0); cycle(); cycle();
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 15) == 0, rnd_pc(),
                  $urandom_range(0, 5) == 0, rnd_pc(),
                  $urandom_range(0, 2) == 0, rnd_pc(),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
            cycle();
        end

        // Asynchronous reset in the middle of a running fetch stream.
        redirect(W'(64'h5000));
        idle(3);
        rst = 1'b1;
        #1;
        chk("async_reset.a_stage_v", 64'(a_sv), 64'd0);
        chk("async_reset.a_fetch_v", 64'(a_fv), 64'd0);
        chk("async_reset.b_stage_v", 64'(b_sv), 64'd0);
        chk("async_reset.b_fetch_v", 64'(b_fv), 64'd0);
        chk("async_reset.b_poison", 64'(b_poison), 64'd0);
        #1;
        rst = 1'b0;
        model_reset();
        redirect(W'(64'h80000000));
        idle(3);

        chk("scoreboard_drained", 64'(qa.size() + qb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
